imem_loader: RTL and testbench

Boot-time instruction loader sitting directly upstream of the CPU core's instruction fetch. It accepts a little-endian byte stream (header word = word count N, then N instruction words), writes each assembled 32-bit word into instruction memory starting at word address 0, and holds the core in reset until the image is complete. A `reload` pulse re-arms it for a new image.

---
 rtl/imem_loader_if.sv | 36 +++
 rtl/imem_loader.sv | 166 ++++++++++++++++
 tb/tb_imem_loader.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// ============================================================================
//  Module      : imem_loader_if
//  Description : Byte-stream, instruction-memory write and core-control
//                signals of the boot-time instruction loader.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface imem_loader_if #(
    parameter int ADDR_W = 10
);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              reload;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_rst;
    logic              done;
    logic              err;

    // Source / system side
    modport master (
        output byte_valid, byte_data, reload,
        input  byte_ready, imem_we, imem_addr, imem_wdata, core_rst, done, err
    );

    // Loader side
    modport slave (
        input  byte_valid, byte_data, reload,
        output byte_ready, imem_we, imem_addr, imem_wdata, core_rst, done, err
    );
endinterface

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
//  Module      : imem_loader
//  Description : Assembles a little-endian byte image (count N, then N words)
//                into instruction memory and holds the core in reset until done.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader #(
    parameter int ADDR_W = 10
) (
    input  wire logic    clk,
    input  wire logic    rst,
    imem_loader_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_DATA = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    localparam logic [32:0] C_CAPACITY = 33'd1 << ADDR_W;

    state_t              r_state_q,    w_state_d;
    logic [1:0]          r_byte_cnt_q, w_byte_cnt_d;
    logic [23:0]         r_shift_q,    w_shift_d;
    logic [ADDR_W:0]     r_count_q,    w_count_d;
    logic [ADDR_W:0]     r_widx_q,     w_widx_d;
    logic                r_we_q,       w_we_d;
    logic [ADDR_W-1:0]   r_addr_q,     w_addr_d;
    logic [31:0]         r_wdata_q,    w_wdata_d;
    logic                r_core_rst_q, w_core_rst_d;
    logic                r_done_q,     w_done_d;
    logic                r_err_q,      w_err_d;

    logic                w_ready;
    logic                w_accept;
    logic                w_last_byte;
    logic [31:0]         w_word;
    logic [ADDR_W:0]     w_widx_inc;

    assign w_ready     = (r_state_q == S_HDR) || (r_state_q == S_DATA);
    assign w_accept    = bus.byte_valid && w_ready;
    assign w_last_byte = (r_byte_cnt_q == 2'd3);
    // Incoming byte lands on top; after four bytes the first one sits in [7:0].
    assign w_word      = {bus.byte_data, r_shift_q};
    assign w_widx_inc  = r_widx_q + 1'b1;

    always_comb begin
        w_state_d    = r_state_q;
        w_byte_cnt_d = r_byte_cnt_q;
        w_shift_d    = r_shift_q;
        w_count_d    = r_count_q;
        w_widx_d     = r_widx_q;
        w_we_d       = 1'b0;
        w_addr_d     = r_addr_q;
        w_wdata_d    = r_wdata_q;
        w_core_rst_d = 1'b1;
        w_done_d     = 1'b0;
        w_err_d      = 1'b0;

        case (r_state_q)
            S_IDLE: begin
                w_state_d    = S_HDR;
                w_byte_cnt_d = 2'd0;
                w_widx_d     = '0;
            end
            S_HDR: begin
                if (w_accept) begin
                    w_shift_d    = w_word[31:8];
                    w_byte_cnt_d = r_byte_cnt_q + 2'd1;
                    if (w_last_byte) begin
                        w_widx_d = '0;
                        if (w_word == 32'd0) begin
                            w_state_d = S_DONE;
                        end else if ({1'b0, w_word} > C_CAPACITY) begin
                            w_state_d = S_ERR;
                        end else begin
                            w_count_d = w_word[ADDR_W:0];
                            w_state_d = S_DATA;
                        end
                    end
                end
            end
            S_DATA: begin
                if (w_accept) begin
                    w_shift_d    = w_word[31:8];
                    w_byte_cnt_d = r_byte_cnt_q + 2'd1;
                    if (w_last_byte) begin
                        w_we_d    = 1'b1;
                        w_addr_d  = r_widx_q[ADDR_W-1:0];
                        w_wdata_d = w_word;
                        w_widx_d  = w_widx_inc;
                        if (w_widx_inc == r_count_q) begin
                            w_state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                if (bus.reload) begin
                    w_state_d    = S_IDLE;
                    w_byte_cnt_d = 2'd0;
                    w_widx_d     = '0;
                end else begin
                    w_core_rst_d = 1'b0;
                    w_done_d     = 1'b1;
                end
            end
            S_ERR: begin
                if (bus.reload) begin
                    w_state_d    = S_IDLE;
                    w_byte_cnt_d = 2'd0;
                    w_widx_d     = '0;
                end else begin
                    w_err_d = 1'b1;
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q    <= S_IDLE;
            r_byte_cnt_q <= 2'd0;
            r_shift_q    <= '0;
            r_count_q    <= '0;
            r_widx_q     <= '0;
            r_we_q       <= 1'b0;
            r_addr_q     <= '0;
            r_wdata_q    <= '0;
            r_core_rst_q <= 1'b1;
            r_done_q     <= 1'b0;
            r_err_q      <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_byte_cnt_q <= w_byte_cnt_d;
            r_shift_q    <= w_shift_d;
            r_count_q    <= w_count_d;
            r_widx_q     <= w_widx_d;
            r_we_q       <= w_we_d;
            r_addr_q     <= w_addr_d;
            r_wdata_q    <= w_wdata_d;
            r_core_rst_q <= w_core_rst_d;
            r_done_q     <= w_done_d;
            r_err_q      <= w_err_d;
        end
    end

    assign bus.byte_ready = w_ready;
    assign bus.imem_we    = r_we_q;
    assign bus.imem_addr  = r_addr_q;
    assign bus.imem_wdata = r_wdata_q;
    assign bus.core_rst   = r_core_rst_q;
    assign bus.done       = r_done_q;
    assign bus.err        = r_err_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Directed self-checking bench for imem_loader (ADDR_W 10 and 2).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   dbl_we;
    logic prev_we10;
    logic prev_we2;

    logic [31:0] wr10_a[$];
    logic [31:0] wr10_d[$];
    logic [31:0] wr2_a[$];
    logic [31:0] wr2_d[$];

    imem_loader_if #(.ADDR_W(10)) b10 ();
    imem_loader_if #(.ADDR_W(2))  b2 ();

    imem_loader #(.ADDR_W(10)) u_dut10 (.clk(clk), .rst(rst), .bus(b10));
    imem_loader #(.ADDR_W(2))  u_dut2  (.clk(clk), .rst(rst), .bus(b2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write log, sampled mid-cycle
    always @(negedge clk) begin
        if (b10.imem_we === 1'b1) begin
            wr10_a.push_back(32'(b10.imem_addr));
            wr10_d.push_back(b10.imem_wdata);
        end
        if (b2.imem_we === 1'b1) begin
            wr2_a.push_back(32'(b2.imem_addr));
            wr2_d.push_back(b2.imem_wdata);
        end
        if ((b10.imem_we === 1'b1 && prev_we10 === 1'b1) ||
            (b2.imem_we === 1'b1 && prev_we2 === 1'b1)) dbl_we++;
        prev_we10 = b10.imem_we;
        prev_we2  = b2.imem_we;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input bit sel);
        return sel ? b2.byte_ready : b10.byte_ready;
    endfunction

    task automatic drive(input bit sel, input logic v, input logic [7:0] d);
        if (sel) begin b2.byte_valid = v;  b2.byte_data = d;  end
        else     begin b10.byte_valid = v; b10.byte_data = d; end
    endtask

    // Returns at posedge+1 after the edge that accepted the byte.
    task automatic send(input bit sel, input logic [7:0] b, input int gap);
        logic r;
        bit   acc;
        drive(sel, 1'b0, 8'h00);
        repeat (gap) @(posedge clk);
        if (gap > 0) #1;
        drive(sel, 1'b1, b);
        acc = 0;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            r = rdy(sel);
            if (gap > 0) chk("ready_in_gap_stream", {63'd0, r}, 64'd1);
            @(posedge clk);
            #1;
            if (r === 1'b1) acc = 1;
        end
        drive(sel, 1'b0, 8'h00);
        if (!acc) chk("byte_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_word(input bit sel, input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) send(sel, w[8*i +: 8], gap);
    endtask

    task automatic do_reload(input bit sel, input string tag);
        if (sel) b2.reload = 1'b1; else b10.reload = 1'b1;
        @(posedge clk);
        #1;
        b2.reload  = 1'b0;
        b10.reload = 1'b0;
        chk({tag, "_core_rst"}, {63'd0, sel ? b2.core_rst : b10.core_rst}, 64'd1);
        chk({tag, "_done"},     {63'd0, sel ? b2.done : b10.done}, 64'd0);
        chk({tag, "_err"},      {63'd0, sel ? b2.err : b10.err}, 64'd0);
        @(posedge clk);
        #1;
        chk({tag, "_ready_hdr"}, {63'd0, rdy(sel)}, 64'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"},    {63'd0, b10.byte_ready}, 64'd0);
        chk({tag, "_we"},       {63'd0, b10.imem_we}, 64'd0);
        chk({tag, "_addr"},     64'(b10.imem_addr), 64'd0);
        chk({tag, "_wdata"},    64'(b10.imem_wdata), 64'd0);
        chk({tag, "_core_rst"}, {63'd0, b10.core_rst}, 64'd1);
        chk({tag, "_done"},     {63'd0, b10.done}, 64'd0);
        chk({tag, "_err"},      {63'd0, b10.err}, 64'd0);
    endtask

    task automatic clear_logs();
        wr10_a.delete(); wr10_d.delete();
        wr2_a.delete();  wr2_d.delete();
    endtask

    task automatic image_two_words(input int gap, input string tag);
        clear_logs();
        send_word(1'b0, 32'd2, gap);
        send_word(1'b0, 32'h0000_0013, gap);
        send_word(1'b0, 32'h0000_006F, gap);
        chk({tag, "_last_we"},    {63'd0, b10.imem_we}, 64'd1);
        chk({tag, "_last_addr"},  64'(b10.imem_addr), 64'd1);
        chk({tag, "_last_wdata"}, 64'(b10.imem_wdata), 64'h6F);
        chk({tag, "_ready_drop"}, {63'd0, b10.byte_ready}, 64'd0);
        chk({tag, "_core_rst_held"}, {63'd0, b10.core_rst}, 64'd1);
        @(posedge clk);
        #1;
        chk({tag, "_done"},     {63'd0, b10.done}, 64'd1);
        chk({tag, "_core_rst"}, {63'd0, b10.core_rst}, 64'd0);
        chk({tag, "_we_low"},   {63'd0, b10.imem_we}, 64'd0);
        chk({tag, "_nwrites"},  64'(wr10_a.size()), 64'd2);
        if (wr10_a.size() == 2) begin
            chk({tag, "_a0"}, 64'(wr10_a[0]), 64'd0);
            chk({tag, "_d0"}, 64'(wr10_d[0]), 64'h13);
            chk({tag, "_a1"}, 64'(wr10_a[1]), 64'd1);
            chk({tag, "_d1"}, 64'(wr10_d[1]), 64'h6F);
        end
    endtask

    initial begin
        checks = 0; errors = 0; dbl_we = 0;
        prev_we10 = 1'b0; prev_we2 = 1'b0;
        b10.byte_valid = 1'b0; b10.byte_data = 8'h00; b10.reload = 1'b0;
        b2.byte_valid  = 1'b0; b2.byte_data  = 8'h00; b2.reload  = 1'b0;
        rst = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_reset_hdr_ready", {63'd0, b10.byte_ready}, 64'd1);

        // Continuous stream
        image_two_words(0, "cont");
        // Extra bytes after completion must be refused
        drive(1'b0, 1'b1, 8'hAB);
        repeat (3) begin
            @(negedge clk);
            chk("done_refuses_byte", {63'd0, b10.byte_ready}, 64'd0);
        end
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 8'h00);
        chk("done_no_extra_write", 64'(wr10_a.size()), 64'd2);
        do_reload(1'b0, "reload1");

        // Same image with 3-cycle gaps between bytes
        image_two_words(3, "gap");
        do_reload(1'b0, "reload2");

        // Empty image
        clear_logs();
        send_word(1'b0, 32'd0, 0);
        chk("n0_ready_drop", {63'd0, b10.byte_ready}, 64'd0);
        @(posedge clk);
        #1;
        chk("n0_done",     {63'd0, b10.done}, 64'd1);
        chk("n0_core_rst", {63'd0, b10.core_rst}, 64'd0);
        drive(1'b0, 1'b1, 8'h55);
        @(negedge clk);
        chk("n0_refuse", {63'd0, b10.byte_ready}, 64'd0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 8'h00);
        chk("n0_no_writes", 64'(wr10_a.size()), 64'd0);

        // Over-capacity header on ADDR_W=2
        send_word(1'b1, 32'd5, 0);
        chk("err_we_none", {63'd0, b2.imem_we}, 64'd0);
        @(posedge clk);
        #1;
        chk("err_set",      {63'd0, b2.err}, 64'd1);
        chk("err_core_rst", {63'd0, b2.core_rst}, 64'd1);
        chk("err_done_low", {63'd0, b2.done}, 64'd0);
        chk("err_ready",    {63'd0, b2.byte_ready}, 64'd0);
        chk("err_no_writes", 64'(wr2_a.size()), 64'd0);
        do_reload(1'b1, "reload_err");

        // Full-capacity image on ADDR_W=2: addresses 0..3, no wrap
        send_word(1'b1, 32'd4, 0);
        for (int k = 0; k < 4; k++)
            send_word(1'b1, 32'h3020_1000 + 32'h0101_0101 * k, 0);
        chk("cap_last_addr", 64'(b2.imem_addr), 64'd3);
        @(posedge clk);
        #1;
        chk("cap_done", {63'd0, b2.done}, 64'd1);
        chk("cap_nwrites", 64'(wr2_a.size()), 64'd4);
        if (wr2_a.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("cap_addr", 64'(wr2_a[k]), 64'(k));
                chk("cap_data", 64'(wr2_d[k]), 64'(32'h3020_1000 + 32'h0101_0101 * k));
            end
        end

        // Asynchronous reset in the middle of a load
        do_reload(1'b0, "reload3");
        send_word(1'b0, 32'd3, 0);
        send_word(1'b0, 32'h1234_5678, 0);
        send(1'b0, 8'hA1, 0);
        send(1'b0, 8'hA2, 0);
        #1;
        rst = 1'b1;
        #1;
        check_reset_vals("midload_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_logs();
        send_word(1'b0, 32'd1, 0);
        send_word(1'b0, 32'hDDCC_BBAA, 0);
        @(posedge clk);
        #1;
        chk("fresh_done", {63'd0, b10.done}, 64'd1);
        chk("fresh_nwrites", 64'(wr10_a.size()), 64'd1);
        if (wr10_a.size() == 1) begin
            chk("fresh_addr", 64'(wr10_a[0]), 64'd0);
            chk("fresh_data", 64'(wr10_d[0]), 64'hDDCC_BBAA);
        end

        chk("we_never_two_cycles", 64'(dbl_we), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
